// File: rtl/tl_ul_responder.sv
// Single-beat TL-UL responder backed by DEPTH x 64-bit storage with byte-lane writes.
// Optional TL_RESPONDER_PIPE_EN lets a new A request fire in the same cycle as a D handshake.
module tl_ul_responder #(
  parameter int unsigned DEPTH   = 16,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter logic        SINK_ID = 1'b0
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [2:0]  a_size,
  input  logic [2:0]  a_source,
  input  logic [31:0] a_address,
  input  logic [7:0]  a_mask,
  input  logic [63:0] a_data,

  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [2:0]  d_size,
  output logic [2:0]  d_source,
  output logic        d_sink,
  output logic        d_denied,
  output logic        d_corrupt,
  output logic [63:0] d_data
);

  localparam int unsigned IW = $clog2(DEPTH);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] D_ACCESS_ACK   = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_D = 3'd1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state;
  logic [63:0]   mem [DEPTH];
  logic [IW-1:0] idx;
  logic          a_fire;
  logic          d_fire;
  logic          addr_hit;
  logic          legal_op;
  logic          is_get;
  logic          denied;
  logic          do_write;
  logic [63:0]   rd_data;

  // Fields that take no part in the response; the name keeps them out of unused-signal lint.
  logic unused_fields;
  assign unused_fields = ^{a_param, a_address[2:0]};

  assign idx      = a_address[3 +: IW];
  assign addr_hit = (a_address[31:3+IW] == BASE[31:3+IW]);
  assign legal_op = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL) ||
                    (a_opcode == OP_GET);
  assign is_get   = (a_opcode == OP_GET);
  assign denied   = !addr_hit || (a_size > 3'd3) || !legal_op;

  // a_ready is held low for the whole reset window, so nothing can fire while reset is high.
`ifdef TL_RESPONDER_PIPE_EN
  assign a_ready = !reset && ((state == IDLE) || d_ready);
`else
  assign a_ready = !reset && (state == IDLE);
`endif

  assign a_fire   = a_valid && a_ready;
  assign d_fire   = d_valid && d_ready;
  assign do_write = a_fire && !denied && !is_get;
  assign rd_data  = (is_get && !denied) ? mem[idx] : 64'd0;
  assign d_param  = 2'd0;

  // NOTE: storage has no reset branch on purpose; contents survive reset and the
  // array maps onto plain RAM instead of a wall of resettable flops.
  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int b = 0; b < 8; b++) begin
        if (a_mask[b]) mem[idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  // NOTE: all state here uses <= so every register samples pre-edge values,
  // which is what lets a D handshake and a new A request share one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      d_valid   <= 1'b0;
      d_opcode  <= 3'd0;
      d_size    <= 3'd0;
      d_source  <= 3'd0;
      d_sink    <= 1'b0;
      d_denied  <= 1'b0;
      d_corrupt <= 1'b0;
      d_data    <= 64'd0;
    end else if (a_fire) begin
      state     <= RESP;
      d_valid   <= 1'b1;
      d_opcode  <= is_get ? D_ACCESS_ACK_D : D_ACCESS_ACK;
      d_size    <= a_size;
      d_source  <= a_source;
      d_sink    <= SINK_ID;
      d_denied  <= denied;
      d_corrupt <= denied && is_get;
      d_data    <= rd_data;
    end else if (d_fire) begin
      // Payload returns to zero whenever no response is offered.
      state     <= IDLE;
      d_valid   <= 1'b0;
      d_opcode  <= 3'd0;
      d_size    <= 3'd0;
      d_source  <= 3'd0;
      d_sink    <= 1'b0;
      d_denied  <= 1'b0;
      d_corrupt <= 1'b0;
      d_data    <= 64'd0;
    end
  end

endmodule

// File: tb/tb_tl_ul_responder.sv
// Bench for tl_ul_responder: transaction-level memory model with a per-cycle compare,
// plus directed sequences with literal expectations. Works with or without TL_RESPONDER_PIPE_EN.
module tb_tl_ul_responder;

  localparam int unsigned DEPTH   = 16;
  localparam logic [31:0] BASE    = 32'h0001_0000;
  localparam logic        SINK_ID = 1'b1;
`ifdef TL_RESPONDER_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] PUT_PART = 3'd1;
  localparam logic [2:0] GET      = 3'd4;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_size, a_source;
  logic [31:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size, d_source;
  logic        d_sink, d_denied, d_corrupt;
  logic [63:0] d_data;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [2:0]  src;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [63:0] model_mem [DEPTH];
  int          errors = 0;
  int          checks = 0;
  bit          started = 1'b0;
  bit          cmp_v;
  resp_t       cmp_e;

  tl_ul_responder #(.DEPTH(DEPTH), .BASE(BASE), .SINK_ID(SINK_ID)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_corrupt(d_corrupt), .d_data(d_data)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
  endfunction

  // Spec-level model: address window, legal opcodes, size limit, byte-lane writes.
  function automatic resp_t model_access(input logic [2:0] op, input logic [2:0] size,
                                         input logic [2:0] src, input logic [31:0] addr,
                                         input logic [7:0] mask, input logic [63:0] data);
    resp_t       r;
    logic [31:0] off;
    bit          in_range, get, den;
    int          w;
    off      = addr - BASE;
    in_range = (addr >= BASE) && (off < 32'(DEPTH * 8));
    get      = (op == GET);
    den      = !in_range || (size > 3'd3) || !(op == PUT_FULL || op == PUT_PART || op == GET);
    w        = int'(off >> 3);
    r.op      = get ? 3'd1 : 3'd0;
    r.size    = size;
    r.src     = src;
    r.denied  = den;
    r.corrupt = den && get;
    r.data    = (get && !den) ? model_mem[w] : 64'd0;
    if (!get && !den) begin
      for (int b = 0; b < 8; b++) begin
        if (mask[b]) model_mem[w][8*b +: 8] = data[8*b +: 8];
      end
    end
    return r;
  endfunction

  // Model update on each edge: reset drops pending responses, D fire retires, A fire enqueues.
  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (d_valid && d_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (a_valid && a_ready)
        exp_q.push_back(model_access(a_opcode, a_size, a_source, a_address, a_mask, a_data));
    end
  end

  always @(negedge clock) begin
    if (started) begin
      cmp_v = (exp_q.size() > 0);
      check("a_ready", a_ready, !reset && (!cmp_v || (PIPE && d_ready)));
      check("d_valid", d_valid, cmp_v);
      if (cmp_v) begin
        cmp_e = exp_q[0];
        check("d_opcode", d_opcode, cmp_e.op);
        check("d_size", d_size, cmp_e.size);
        check("d_source", d_source, cmp_e.src);
        check("d_denied", d_denied, cmp_e.denied);
        check("d_corrupt", d_corrupt, cmp_e.corrupt);
        check("d_data", d_data, cmp_e.data);
        check("d_param", d_param, 0);
        check("d_sink", d_sink, SINK_ID);
      end else begin
        check("idle_fields", {d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt}, 0);
        check("idle_data", d_data, 0);
      end
    end
  end

  // Present a request and hold it until accepted; returns #1 after the accepting edge.
  task automatic drive_a(input logic [2:0] op, input logic [2:0] size, input logic [2:0] src,
                         input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data);
    bit ok = 1'b0;
    a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
    a_address = addr; a_mask = mask; a_data = data;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      ok = a_ready;
      @(posedge clock);
      #1;
      if (ok) break;
    end
    check("a_accept", ok, 1);
  endtask

  // One complete transaction with d_ready high; captures the response it produced.
  task automatic req(input logic [2:0] op, input logic [2:0] size, input logic [2:0] src,
                     input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data,
                     output resp_t r);
    bit found = 1'b0;
    r = '0;
    drive_a(op, size, src, addr, mask, data);
    a_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (d_valid) begin
        r = '{op: d_opcode, size: d_size, src: d_source, denied: d_denied,
              corrupt: d_corrupt, data: d_data};
        found = 1'b1;
        break;
      end
    end
    check("d_seen", found, 1);
    @(posedge clock);
    #1;
  endtask

  resp_t       r;
  logic [63:0] got [4];
  int          at [4];
  int          n;

  initial begin
    reset = 1'b1; d_ready = 1'b1; a_valid = 1'b0; a_opcode = 3'd0; a_param = 3'd0;
    a_size = 3'd0; a_source = 3'd0; a_address = 32'd0; a_mask = 8'd0; a_data = 64'd0;

    @(posedge clock); #1 started = 1'b1;
    @(negedge clock);
    check("rst_a_ready", a_ready, 0);
    check("rst_d_valid", d_valid, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("post_rst_a_ready", a_ready, 1);
    @(posedge clock); #1;

    for (int i = 0; i < int'(DEPTH); i++) req(PUT_FULL, 3'd3, 3'd0, BASE + 32'(i * 8), 8'hFF, pat(i), r);

    // Full write then readback.
    req(PUT_FULL, 3'd3, 3'd2, BASE + 32'h8, 8'hFF, 64'h1122_3344_5566_7788, r);
    check("put_op", r.op, 0);
    check("put_data", r.data, 0);
    req(GET, 3'd3, 3'd2, BASE + 32'h8, 8'h00, 64'd0, r);
    check("get_op", r.op, 1);
    check("get_data", r.data, 64'h1122_3344_5566_7788);
    check("get_denied", r.denied, 0);

    // Partial write over word 0.
    req(PUT_PART, 3'd3, 3'd1, BASE, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, r);
    check("ppart_op", r.op, 0);
    req(GET, 3'd3, 3'd1, BASE, 8'h00, 64'd0, r);
    check("ppart_data", r.data, 64'hA5A5_0000_AAAA_AAAA);

    // Denials: out-of-window, bad size, reserved opcodes.
    req(GET, 3'd3, 3'd3, BASE + 32'(DEPTH * 8), 8'h00, 64'd0, r);
    check("oob_get_op", r.op, 1);
    check("oob_get_flags", {r.denied, r.corrupt}, 2'b11);
    check("oob_get_data", r.data, 0);
    req(PUT_FULL, 3'd3, 3'd3, BASE + 32'(DEPTH * 8), 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, r);
    check("oob_put_flags", {r.op, r.denied, r.corrupt}, 5'b000_10);
    req(GET, 3'd3, 3'd3, BASE - 32'h8, 8'h00, 64'd0, r);
    check("below_get_denied", r.denied, 1);
    req(PUT_FULL, 3'd4, 3'd4, BASE + 32'h10, 8'hFF, 64'd0, r);
    check("size_put_denied", r.denied, 1);
    req(3'd2, 3'd3, 3'd4, BASE + 32'h18, 8'hFF, 64'd0, r);
    check("op2_flags", {r.op, r.denied, r.corrupt}, 5'b000_10);
    req(3'd5, 3'd3, 3'd4, BASE + 32'h18, 8'hFF, 64'd0, r);
    check("op5_flags", {r.op, r.denied, r.corrupt}, 5'b000_10);
    req(GET, 3'd5, 3'd4, BASE + 32'h18, 8'h00, 64'd0, r);
    check("size_get_flags", {r.op, r.denied, r.corrupt}, 5'b001_11);
    req(GET, 3'd3, 3'd0, BASE, 8'h00, 64'd0, r);
    check("w0_unchanged", r.data, 64'hA5A5_0000_AAAA_AAAA);
    req(GET, 3'd3, 3'd0, BASE + 32'h10, 8'h00, 64'd0, r);
    check("w2_unchanged", r.data, pat(2));
    req(GET, 3'd3, 3'd0, BASE + 32'h18, 8'h00, 64'd0, r);
    check("w3_unchanged", r.data, pat(3));

    // Byte lanes follow the mask regardless of a_size.
    req(PUT_FULL, 3'd2, 3'd6, BASE + 32'h48, 8'hF0, 64'hDEAD_BEEF_0000_0000, r);
    req(GET, 3'd3, 3'd6, BASE + 32'h48, 8'h00, 64'd0, r);
    check("mask_hi_data", r.data, 64'hDEAD_BEEF_5A5A_0009);

    // Backpressure: response held stable with d_ready low.
    d_ready = 1'b0;
    drive_a(GET, 3'd3, 3'd5, BASE + 32'h30, 8'h00, 64'd0);
    a_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("stall_valid", d_valid, 1);
      check("stall_data", d_data, pat(6));
      check("stall_source", d_source, 5);
      check("stall_a_ready", a_ready, 0);
    end
    d_ready = 1'b1;
    @(posedge clock); #1;

    // Four back-to-back Gets; spacing depends on pipelining.
    n = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) drive_a(GET, 3'd3, 3'(i), BASE + 32'((4 + i) * 8), 8'h00, 64'd0);
        a_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && n < 4; c++) begin
          @(negedge clock);
          if (d_valid) begin
            got[n] = d_data;
            at[n]  = c;
            n++;
          end
        end
      end
    join
    check("b2b_count", n, 4);
    for (int i = 0; i < 4; i++) check("b2b_data", got[i], pat(4 + i));
    check("b2b_span", at[3] - at[0], PIPE ? 3 : 6);
    @(posedge clock); #1;

    // Reset while a response is pending.
    d_ready = 1'b0;
    drive_a(GET, 3'd3, 3'd1, BASE + 32'h28, 8'h00, 64'd0);
    a_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_resp_d_valid", d_valid, 0);
    check("rst_resp_a_ready", a_ready, 0);
    check("rst_resp_d_data", d_data, 0);
    @(posedge clock); #1 reset = 1'b0; d_ready = 1'b1;
    @(negedge clock);
    check("rst_exit_a_ready", a_ready, 1);
    @(posedge clock); #1;
    req(GET, 3'd3, 3'd1, BASE + 32'h28, 8'h00, 64'd0, r);
    check("retain_w5", r.data, pat(5));
    req(GET, 3'd3, 3'd1, BASE + 32'h8, 8'h00, 64'd0, r);
    check("retain_w1", r.data, 64'h1122_3344_5566_7788);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_ul_responder.md
TL_UL_RESPONDER -- requirements
Module: tl_ul_responder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEPTH, 16, number of 64-bit storage words; power of two, 2..256.
- BASE, 32'h0000_0000, base address; aligned to DEPTH*8.
- SINK_ID, 1'b0, value driven on d_sink.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1, sole clock.
- reset, in, 1, synchronous active-high reset.
- a_valid, in, 1, A request valid.
- a_ready, out, 1, A request accepted.
- a_opcode, in, 3, TL-UL A opcode.
- a_param, in, 3, ignored.
- a_size, in, 3, log2 bytes.
- a_source, in, 3, requester ID.
- a_address, in, 32, byte address.
- a_mask, in, 8, byte lanes.
- a_data, in, 64, write data.
- d_valid, out, 1, D response valid.
- d_ready, in, 1, D response accepted.
- d_opcode, out, 3, D opcode.
- d_param, out, 2, always 0.
- d_size, out, 3, echo of a_size.
- d_source, out, 3, echo of a_source.
- d_sink, out, 1, SINK_ID.
- d_denied, out, 1, request refused.
- d_corrupt, out, 1, data invalid.
- d_data, out, 64, read data.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high, with ports named clock and reset.

Function
REQ-004 The block SHALL be the responder end of a single-beat TL-UL A/D link, with storage of DEPTH x 64-bit words.
REQ-005 The FSM SHALL have two states:
- IDLE: a_ready=1, d_valid=0.
- RESP: d_valid=1.
REQ-006 A fire (a_valid & a_ready) SHALL capture opcode, size and source, and move the FSM to RESP; d_valid SHALL rise exactly one cycle after the A fire.
REQ-007 In RESP, all d_* outputs SHALL be held stable until d_ready=1; D fire SHALL return the FSM to IDLE unless REQ-016 applies.
REQ-008 Get (4) SHALL respond with AccessAckData (1), carrying d_data = word at index a_address[3+log2(DEPTH)-1:3] as of the A fire cycle.
REQ-009 PutFullData (0) and PutPartialData (1) SHALL write only the bytes whose a_mask bit is 1, in the A fire cycle, and SHALL respond with AccessAck (0) and d_data=0.
REQ-010 The block SHALL deny a request (d_denied=1, no storage write, d_data=0) when any of the following holds:
- a_address[31:3+log2(DEPTH)] differs from BASE's corresponding bits;
- a_size > 3;
- the opcode is 2, 3, 5, 6 or 7.
REQ-011 Denied Get SHALL return AccessAckData with d_corrupt=1; every other response SHALL have d_corrupt=0.
REQ-012 Denied non-Get requests SHALL return AccessAck.
REQ-013 A Get accepted after a Put to the same word SHALL return the post-write data.
REQ-014 When d_valid=0, the d_* payload outputs SHALL be driven to 0.

Reset
REQ-015 While reset=1, the block SHALL:
- put the FSM in IDLE, with a_ready=0, d_valid=0 and all d_* outputs 0;
- drop any pending response;
- leave storage contents unchanged (storage is not reset).
REQ-015a The first cycle after reset deasserts SHALL have a_ready=1.

Configuration
REQ-016 With TL_RESPONDER_PIPE_EN defined, RESP SHALL drive a_ready=d_ready, so an A fire and a D fire in the same cycle keep the FSM in RESP with the new response on the next cycle (one request per cycle sustained).
REQ-017 Without TL_RESPONDER_PIPE_EN, a_ready SHALL be 0 in RESP, so a single outstanding request is allowed and peak throughput is one request per two cycles.

Verification
REQ-018 Put 0x1122334455667788, mask 0xFF, to BASE+0x8, then Get BASE+0x8 -> AccessAck, then AccessAckData with d_data 0x1122334455667788, d_denied=0.
REQ-019 PutPartial 0xAAAA..., mask 0x0F, over word 0, then Get -> low 4 bytes 0xAA, high 4 bytes unchanged.
REQ-020 Get at BASE+DEPTH*8 -> AccessAckData with d_denied=1, d_corrupt=1, d_data=0; no storage change.
REQ-021 Hold d_ready=0 for 5 cycles after a Get -> d_valid and payload stable; a_ready=0 (no PIPE_EN); d_source echoes a_source=5.
REQ-022 With PIPE_EN, 4 back-to-back Gets and d_ready=1 -> 4 responses on 4 consecutive cycles, in order.
REQ-023 Assert reset while in RESP -> d_valid=0 the next cycle; a_ready=1 the cycle after reset drops; storage retains data.
